// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Fetch PC register with EX-stage branch/jump redirect, pipeline
//               flush strobes and redirect holding across global freezes.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic [WIDTH-1:0] target,
    input  logic             stall_fe,
    input  logic             freeze,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redirect_pending,
    output logic             misalign_err
);

    localparam logic [WIDTH-1:0] c_four = WIDTH'(4);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_pend_tgt, w_pend_tgt_nxt;
    logic             r_misalign;
    logic             w_misalign_set;
    logic             w_flush;
    logic             w_req;
    logic             w_tgt_misaligned;
    logic [WIDTH-1:0] w_atgt;
    logic [WIDTH-1:0] w_pc_plus4;

    assign w_req            = ex_valid & (branch_taken | jump);
    assign w_atgt           = {target[WIDTH-1:2], 2'b00};
    assign w_tgt_misaligned = |target[1:0];
    assign w_pc_plus4       = r_pc + c_four;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_pend_tgt <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_misalign <= r_misalign | w_misalign_set;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_tgt_nxt = r_pend_tgt;
        w_flush        = 1'b0;
        w_misalign_set = 1'b0;
        case (r_state)
            S_RUN: begin
                if (freeze) begin
                    // Freeze has priority: park the redirect until the pipe moves.
                    if (w_req) begin
                        w_pend_tgt_nxt = w_atgt;
                        w_state_nxt    = S_HOLD;
                        w_misalign_set = w_tgt_misaligned;
                    end
                end else if (w_req) begin
                    w_flush        = 1'b1;
                    w_pc_nxt       = w_atgt;
                    w_misalign_set = w_tgt_misaligned;
                end else if (!stall_fe) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            S_HOLD: begin
                // EX is re-presenting the same instruction; only the parked target counts.
                if (!freeze) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = r_pend_tgt;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign flush_ifid       = w_flush & ~reset;
    assign flush_idex       = w_flush & ~reset;
    assign redirect_pending = (r_state == S_HOLD);
    assign misalign_err     = r_misalign;

endmodule
`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter and control-flow redirect stage for the RV32IM 5-stage pipeline (IF/ID/EX/MEM/WB).
- Sits directly downstream of the EX-stage branch decision (the branch-taken bit) and the jump resolution.
- Owns the PC register and applies taken branches and jumps to the fetch address.
- Generates flush strobes for the IF/ID and ID/EX pipeline registers, and holds a redirect across global pipeline freezes.

Parameters:
- WIDTH, 32: PC and target width in bits.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- EX_VALID  input  1  EX stage holds a real instruction (not a bubble); qualifies redirects.
- BRANCH_TAKEN  input  1  conditional branch in EX resolved taken.
- JUMP  input  1  JAL/JALR in EX.
- TARGET  input  WIDTH  redirect target computed in EX.
- STALL_FE  input  1  load-use stall from hazard unit; freezes PC only.
- FREEZE  input  1  global freeze (mul/div busy, memory wait); whole pipeline holds.
- PC  output  WIDTH  current fetch address (registered).
- PC_PLUS4  output  WIDTH  PC+4, combinational, wraps modulo 2^WIDTH.
- FLUSH_IFID  output  1  clear IF/ID at next edge (combinational).
- FLUSH_IDEX  output  1  clear ID/EX at next edge (combinational).
- REDIRECT_PENDING  output  1  redirect captured during freeze, not yet applied (registered).
- MISALIGN_ERR  output  1  sticky: a redirect target had TARGET[1:0] != 0.

Behaviour:
- Reset (RESET high at edge): PC=RESET_PC, state=RUN, pending target=0, REDIRECT_PENDING=0, MISALIGN_ERR=0.
- RESET overrides every other input, including a redirect in HOLD; the pending redirect is discarded.
- Redirect request: req = EX_VALID & (BRANCH_TAKEN | JUMP). BRANCH_TAKEN and JUMP together count as one redirect.
- Aligned target: atgt = {TARGET[WIDTH-1:2], 2'b00}. Any accepted or captured target with nonzero low bits sets MISALIGN_ERR, which stays 1 until reset.
- States: RUN and HOLD.
- RUN, FREEZE=1, req=1: capture atgt as the pending target and go to HOLD. PC holds, no flush.
- RUN, FREEZE=1, req=0: PC holds, no flush.
- RUN, FREEZE=0, req=1: FLUSH_IFID=FLUSH_IDEX=1 this cycle, PC<=atgt. The redirect wins over STALL_FE.
- RUN, FREEZE=0, req=0, STALL_FE=1: PC holds, no flush.
- RUN otherwise: PC<=PC+4.
- HOLD: REDIRECT_PENDING=1. Inputs req and TARGET are ignored (the EX instruction is held and re-presented).
- HOLD, FREEZE=1: PC holds, no flush.
- HOLD, FREEZE=0: FLUSH_IFID=FLUSH_IDEX=1 this cycle, PC<=pending target, go to RUN. STALL_FE is ignored on this cycle.
- Flush outputs are 0 in every case not listed above, including during reset.
- Latency: the redirect target appears on PC one edge after acceptance. There is exactly one flush cycle per redirect.
- Priority: RESET > FREEZE > redirect > STALL_FE > increment.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag.

Test Plan:
1. RESET high for 2 cycles, then idle inputs -> PC=0x0, then 0x4, 0x8, 0xC on successive edges; flushes stay 0; PC_PLUS4 tracks PC+4.
2. At PC=0x10, EX_VALID=1, BRANCH_TAKEN=1, TARGET=0x100 -> flushes=1 that cycle; PC=0x100 next edge, then 0x104; flushes back to 0.
3. EX_VALID=0 with BRANCH_TAKEN=1, JUMP=1, TARGET=0x100 -> no flush, PC advances by 4.
4. FREEZE=1 for 3 cycles with JUMP=1, TARGET=0x200, TARGET changed to 0x300 in cycle 2 -> PC frozen, REDIRECT_PENDING=1 from the second cycle, no flush. FREEZE=0 -> flushes=1 that cycle, PC=0x200 next edge (not 0x300), REDIRECT_PENDING=0.
5. STALL_FE=1 with BRANCH_TAKEN=1, EX_VALID=1, TARGET=0x80 -> flushes=1, PC=0x80 next edge. STALL_FE=1 alone -> PC holds, no flush.
6. TARGET=0x102 accepted -> PC=0x100, MISALIGN_ERR=1 stays set. Then enter HOLD and assert RESET -> PC=RESET_PC, REDIRECT_PENDING=0, MISALIGN_ERR=0, no flush on release.
